calc_cmd_sequencer: RTL and testbench
=====================================

CALC_CMD_SEQUENCER -- requirements
Module: calc_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth in entries (power of two, >=2).
REQ-002 SHALL have parameter CALC_LAT, default 1, cycles from operands sampled by int_calc_16 to out_calc valid (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  upstream command valid.
REQ-006 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-007 SHALL have port cmd_op  input  3  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod.
REQ-008 SHALL have ports cmd_opa and cmd_opb  input  64 each  operands.
REQ-009 SHALL have port operation  output  3  registered opcode driven to int_calc_16.
REQ-010 SHALL have ports opa_calc and opb_calc  output  64 each  registered operands driven to int_calc_16.
REQ-011 SHALL have port out_calc  input  64  int_calc_16 result.
REQ-012 SHALL have port res_valid  output  1  result available.
REQ-013 SHALL have port res_ready  input  1  downstream accepts result.
REQ-014 SHALL have port res_data  output  64  captured result.
REQ-015 SHALL have port res_err  output  1  command rejected (invalid opcode or divide/mod by zero).
REQ-016 SHALL have port res_op  output  3  opcode of the command the result belongs to.
REQ-017 SHALL have port busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-018 SHALL push {cmd_op,cmd_opa,cmd_opb} on any edge where cmd_valid && cmd_ready; cmd_ready = (count != DEPTH), derived from registered count only.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if FIFO non-empty, pop head, load operation/opa_calc/opb_calc, go ISSUE; else stay.
REQ-021 ISSUE: if operation > 4, or operation in {3,4} with opb_calc == 0, set res_data=0, res_err=1, go RESP; else load counter = CALC_LAT, go WAIT.
REQ-022 WAIT: if counter == 1, capture out_calc into res_data verbatim, res_err=0, go RESP; else decrement.
REQ-023 RESP: res_valid=1; on edge with res_ready=1 drop res_valid, go IDLE; res_data/res_err/res_op held stable while res_valid && !res_ready.
REQ-024 operation/opa_calc/opb_calc SHALL hold stable from IDLE pop through capture or error decision; change only in IDLE.
REQ-025 Latency: command pushed at edge N into empty FIFO with FSM IDLE -> res_valid rises at edge N+2+CALC_LAT (valid op), N+2 (error op).
REQ-026 Simultaneous push and pop on one edge SHALL be legal; count unchanged; pointers wrap modulo DEPTH.
REQ-027 Push when full impossible (cmd_ready low); pop when empty never occurs (IDLE waits).
REQ-028 Commands SHALL complete strictly in acceptance order; no command dropped or duplicated.

Reset
REQ-029 On edge with rst_n=0: FIFO flushed (count 0, pointers 0), FSM IDLE, counter 0, all outputs 0 except cmd_ready=1.
REQ-030 Reset in any state, including mid-WAIT or RESP, SHALL discard in-flight and queued commands; no res_valid after release until a new command is pushed.

Verification
REQ-031 Push op0 opa=25 opb=30 -> res_valid at N+3 (CALC_LAT=1), res_data=55, res_err=0, res_op=0.
REQ-032 Push op1 25,30 then op1 20,5 back-to-back, res_ready=1 -> results 0xFFFFFFFFFFFFFFFB then 15, in order.
REQ-033 Push op3 10,2 then op4 10,2 -> res_data 5 then 0; op2 4,5 -> 20.
REQ-034 Push op3 opb=0, then op6 -> each res_data=0, res_err=1, res_valid at N+2; int_calc result ignored.
REQ-035 Hold res_ready=0, push 6 commands continuously -> 5 accepted (1 in FSM + DEPTH), cmd_ready low at 6th; release res_ready -> all 5 results in order, res_data stable while stalled.
REQ-036 Assert rst_n=0 for one cycle during WAIT with 2 queued -> all outputs 0, cmd_ready=1, busy=0, no further res_valid.

Source files
------------

// File: rtl/calc_cmd_sequencer.sv
// Command FIFO feeding int_calc_16: queues {op, opa, opb}, issues one command at a time,
// rejects invalid or divide-by-zero commands, and holds each result until downstream accepts it.
module calc_cmd_sequencer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CALC_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [63:0] cmd_opa,
    input  logic [63:0] cmd_opb,
    output logic [2:0]  operation,
    output logic [63:0] opa_calc,
    output logic [63:0] opb_calc,
    input  logic [63:0] out_calc,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic        res_err,
    output logic [2:0]  res_op,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = $clog2(CALC_LAT + 1);

    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] opa;
        logic [63:0] opb;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [LW-1:0] counter;
    state_t        state;
    state_t        state_next;

    logic push;
    logic pop;
    logic load_cnt;
    logic dec_cnt;
    logic cap_ok;
    logic cap_err;
    logic resp_done;
    logic op_bad;

    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (count != '0) || (state != IDLE);
    assign op_bad    = (operation > 3'd4) ||
                       (((operation == 3'd3) || (operation == 3'd4)) && (opb_calc == 64'd0));

    // Next-state and per-state control strobes
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_cnt   = 1'b0;
        dec_cnt    = 1'b0;
        cap_ok     = 1'b0;
        cap_err    = 1'b0;
        resp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (op_bad) begin
                    cap_err    = 1'b1;
                    state_next = RESP;
                end else begin
                    load_cnt   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (counter == LW'(1)) begin
                    cap_ok     = 1'b1;
                    state_next = RESP;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    resp_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a flush only clears the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: cmd_op, opa: cmd_opa, opb: cmd_opb};
    end

    // Operand registers change only on a pop; result registers load on capture/reject
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            operation <= '0;
            opa_calc  <= '0;
            opb_calc  <= '0;
            counter   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_op    <= '0;
        end else begin
            if (pop) begin
                operation <= mem[rd_ptr].op;
                opa_calc  <= mem[rd_ptr].opa;
                opb_calc  <= mem[rd_ptr].opb;
            end
            if (load_cnt)     counter <= LW'(CALC_LAT);
            else if (dec_cnt) counter <= counter - LW'(1);
            else if (cap_ok)  counter <= '0;
            if (cap_ok) begin
                res_valid <= 1'b1;
                res_data  <= out_calc;
                res_err   <= 1'b0;
                res_op    <= operation;
            end else if (cap_err) begin
                res_valid <= 1'b1;
                res_data  <= '0;
                res_err   <= 1'b1;
                res_op    <= operation;
            end else if (resp_done) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Self-checking bench for calc_cmd_sequencer with a behavioural one-cycle int_calc_16 model.
module tb_calc_cmd_sequencer;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CALC_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [63:0] cmd_opa;
    logic [63:0] cmd_opb;
    logic [2:0]  operation;
    logic [63:0] opa_calc;
    logic [63:0] opb_calc;
    logic [63:0] out_calc = 64'd0;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_err;
    logic [2:0]  res_op;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] got_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    calc_cmd_sequencer #(.DEPTH(DEPTH), .CALC_LAT(CALC_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb),
        .operation(operation), .opa_calc(opa_calc), .opb_calc(opb_calc),
        .out_calc(out_calc),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .res_op(res_op),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Calculator model; an illegal request yields a marker value that must never be captured
    always @(posedge clk) begin
        case (operation)
            3'd0:    out_calc <= opa_calc + opb_calc;
            3'd1:    out_calc <= opa_calc - opb_calc;
            3'd2:    out_calc <= opa_calc * opb_calc;
            3'd3:    out_calc <= (opb_calc != 0) ? opa_calc / opb_calc : 64'hDEAD_BEEF;
            3'd4:    out_calc <= (opb_calc != 0) ? opa_calc % opb_calc : 64'hDEAD_BEEF;
            default: out_calc <= 64'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk) begin
        if (rst_n && res_valid && res_ready) got_q.push_back(res_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        cmd_op    = op;
        cmd_opa   = a;
        cmd_opb   = b;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_operation"}, 64'(operation), 64'd0);
        chk({tag, "_opa"}, opa_calc, 64'd0);
        chk({tag, "_opb"}, opb_calc, 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_res_data"}, res_data, 64'd0);
        chk({tag, "_res_err"}, 64'(res_err), 64'd0);
        chk({tag, "_res_op"}, 64'(res_op), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_single(input vec_t v, input int idx);
        int lat;
        int exp_lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        lat = 0;
        exp_lat = v.exp_err ? 2 : 2 + int'(CALC_LAT);
        res_ready = 1'b0;
        push_cmd(v.op, v.a, v.b);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, res_data, v.exp_data);
        chk({tag, "_err"}, 64'(res_err), 64'(v.exp_err));
        chk({tag, "_op"}, 64'(res_op), 64'(v.op));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_valid_dropped"}, 64'(res_valid), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int acc;
        int waited;
        logic seen;

        vecs[0] = '{3'd0, 64'd25, 64'd30, 64'd55, 1'b0};
        vecs[1] = '{3'd1, 64'd25, 64'd30, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
        vecs[2] = '{3'd1, 64'd20, 64'd5, 64'd15, 1'b0};
        vecs[3] = '{3'd3, 64'd10, 64'd2, 64'd5, 1'b0};
        vecs[4] = '{3'd4, 64'd10, 64'd2, 64'd0, 1'b0};
        vecs[5] = '{3'd2, 64'd4, 64'd5, 64'd20, 1'b0};
        vecs[6] = '{3'd3, 64'd7, 64'd0, 64'd0, 1'b1};
        vecs[7] = '{3'd6, 64'd1, 64'd2, 64'd0, 1'b1};
        vecs[8] = '{3'd4, 64'd5, 64'd0, 64'd0, 1'b1};
        vecs[9] = '{3'd7, 64'd9, 64'd3, 64'd0, 1'b1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_opa   = '0;
        cmd_opb   = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 10; i++) run_single(vecs[i], i);

        // Back-to-back pushes with downstream always ready
        got_q.delete();
        res_ready = 1'b1;
        push_cmd(3'd1, 64'd25, 64'd30);
        push_cmd(3'd1, 64'd20, 64'd5);
        waited = 0;
        while (got_q.size() < 2 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("b2b_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() >= 2) begin
            chk("b2b_first", got_q[0], 64'hFFFF_FFFF_FFFF_FFFB);
            chk("b2b_second", got_q[1], 64'd15);
        end
        res_ready = 1'b0;
        @(posedge clk); #1;

        // Fill while stalled: one command in the FSM plus DEPTH queued
        got_q.delete();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_op    = 3'd0;
            cmd_opa   = 64'(i);
            cmd_opb   = 64'd1;
            cmd_valid = 1'b1;
            if (i == 5) chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
            if (cmd_ready) acc++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("full_accepted", 64'(acc), 64'd5);
        chk("stall_valid", 64'(res_valid), 64'd1);
        chk("stall_data", res_data, 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_hold_data", res_data, 64'd1);
            chk("stall_hold_valid", 64'(res_valid), 64'd1);
        end
        res_ready = 1'b1;
        waited = 0;
        while (got_q.size() < 5 && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk("drain_count", 64'(got_q.size()), 64'd5);
        for (int j = 0; j < got_q.size() && j < 5; j++)
            chk($sformatf("drain_%0d", j), got_q[j], 64'(j + 1));
        chk("drain_busy", 64'(busy), 64'd0);
        res_ready = 1'b0;

        // Reset during WAIT with two commands still queued
        push_cmd(3'd0, 64'd1, 64'd2);
        push_cmd(3'd0, 64'd3, 64'd4);
        push_cmd(3'd0, 64'd5, 64'd6);
        chk("mid_wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_idle_outputs("midreset");
        res_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        chk("no_valid_after_reset", 64'(seen), 64'd0);
        res_ready = 1'b0;

        run_single(vecs[0], 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
